probe_req_queue: RTL and testbench

- Request front-end sitting directly upstream of the probe buffer black box in the fuzzing simulation harness.
- Accepts 64-bit probe commands from the core-side MMIO path, together with their per-bit taint, into a small FIFO.
- Issues the commands to the probe buffer one at a time and captures the probe buffer's read data and read taint.
- Returns each result to the requester over a valid/ready response channel, with a counter of issued and secret-request commands.

---
 rtl/probe_req_queue.sv | 135 +++++++++++++
 tb/tb_probe_req_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/probe_req_queue.sv
// Request front-end for the probe buffer: buffers probe commands with their taint,
// issues them one at a time and returns the captured result over a valid/ready channel.
module probe_req_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [63:0] SECRET_CMD = 64'hAF1B_608E_883D_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_data,
    input  logic [63:0] req_data_taint,
    output logic        pb_wen,
    output logic        pb_wen_taint,
    output logic [63:0] pb_write,
    output logic [63:0] pb_write_taint,
    input  logic [63:0] pb_read,
    input  logic [63:0] pb_read_taint,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [63:0] resp_taint,
    output logic        resp_secret,
    output logic [31:0] issue_count,
    output logic [15:0] secret_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_r;
    logic [63:0]        data_mem_r  [DEPTH];
    logic [63:0]        taint_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               is_secret_r;
    logic               enq_s;
    logic               deq_s;

    // Full is judged from the registered count only, so req_ready never depends on req_valid.
    assign req_ready    = (count_r != CNT_W'(DEPTH));
    assign enq_s        = req_valid && req_ready;
    assign deq_s        = (state_r == ST_IDLE) && (count_r != CNT_W'(0));
    assign pb_wen_taint = 1'b0;

    // Entry storage: command word and its taint are written together.
    always_ff @(posedge clock) begin
        if (enq_s) begin
            data_mem_r[wr_ptr_r]  <= req_data;
            taint_mem_r[wr_ptr_r] <= req_data_taint;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue/response sequencer: one command outstanding, result captured at the end of ISSUE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            pb_wen         <= 1'b0;
            pb_write       <= 64'd0;
            pb_write_taint <= 64'd0;
            is_secret_r    <= 1'b0;
            resp_valid     <= 1'b0;
            resp_data      <= 64'd0;
            resp_taint     <= 64'd0;
            resp_secret    <= 1'b0;
            issue_count    <= 32'd0;
            secret_count   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (deq_s) begin
                        pb_write       <= data_mem_r[rd_ptr_r];
                        pb_write_taint <= taint_mem_r[rd_ptr_r];
                        is_secret_r    <= (data_mem_r[rd_ptr_r] == SECRET_CMD);
                        pb_wen         <= 1'b1;
                        state_r        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The probe buffer has updated pb_read on the negedge inside this cycle.
                    pb_wen      <= 1'b0;
                    resp_data   <= pb_read;
                    resp_taint  <= pb_read_taint;
                    resp_secret <= is_secret_r;
                    resp_valid  <= 1'b1;
                    issue_count <= issue_count + 32'd1;
                    if (is_secret_r && (secret_count != 16'hFFFF)) begin
                        secret_count <= secret_count + 16'd1;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    pb_wen     <= 1'b0;
                    resp_valid <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_probe_req_queue.sv
// Bench for probe_req_queue: directed scenarios plus random traffic, compared each cycle
// against a transaction-level queue model with a behavioural probe buffer.
module tb_probe_req_queue;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] SECRET = 64'hAF1B_608E_883D_0000;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_data;
    logic [63:0] req_data_taint;
    logic        pb_wen;
    logic        pb_wen_taint;
    logic [63:0] pb_write;
    logic [63:0] pb_write_taint;
    logic [63:0] pb_read;
    logic [63:0] pb_read_taint;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [63:0] resp_taint;
    logic        resp_secret;
    logic [31:0] issue_count;
    logic [15:0] secret_count;

    int n_vec  = 0;
    int n_miss = 0;
    bit mon_en = 1'b0;

    probe_req_queue #(.DEPTH(DEPTH), .SECRET_CMD(SECRET)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_data_taint(req_data_taint),
        .pb_wen(pb_wen), .pb_wen_taint(pb_wen_taint),
        .pb_write(pb_write), .pb_write_taint(pb_write_taint),
        .pb_read(pb_read), .pb_read_taint(pb_read_taint),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_taint(resp_taint), .resp_secret(resp_secret),
        .issue_count(issue_count), .secret_count(secret_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] pb_fn(input logic [63:0] c);
        return (c == 64'h1234) ? 64'hDEAD_BEEF : ({c[31:0], c[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0);
    endfunction

    function automatic logic [63:0] pbt_fn(input logic [63:0] c, input logic [63:0] t);
        return (c == SECRET) ? 64'hFFFF_FFFF_FFFF_FFFF : {t[31:0], t[63:32]};
    endfunction

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Probe buffer stand-in: result valid from the negedge of the write-strobe cycle, junk otherwise.
    initial begin
        pb_read       = 64'd0;
        pb_read_taint = 64'd0;
    end
    always @(negedge clock) begin
        if (pb_wen === 1'b1) begin
            pb_read       = pb_fn(pb_write);
            pb_read_taint = pbt_fn(pb_write, pb_write_taint);
        end else begin
            pb_read       = {$urandom, $urandom};
            pb_read_taint = {$urandom, $urandom};
        end
    end

    // Reference model: pending commands in a queue, at most one command on the bus or awaiting pickup.
    logic [63:0] m_qd[$];
    logic [63:0] m_qt[$];
    bit          m_issuing = 1'b0;
    bit          m_holding = 1'b0;
    logic [63:0] m_cmd = 64'd0, m_cmd_t = 64'd0;
    logic [63:0] m_pbw = 64'd0, m_pbwt = 64'd0;
    logic [63:0] m_rd = 64'd0, m_rt = 64'd0;
    logic        m_rs = 1'b0;
    logic [31:0] m_ic = 32'd0;
    logic [15:0] m_sc = 16'd0;

    always @(negedge clock) begin
        logic acc;
        if (mon_en) begin
            chk_val("req_ready",      64'(req_ready),      64'(m_qd.size() < DEPTH));
            chk_val("pb_wen",         64'(pb_wen),         64'(m_issuing));
            chk_val("pb_wen_taint",   64'(pb_wen_taint),   64'd0);
            chk_val("pb_write",       pb_write,            m_pbw);
            chk_val("pb_write_taint", pb_write_taint,      m_pbwt);
            chk_val("resp_valid",     64'(resp_valid),     64'(m_holding));
            chk_val("resp_data",      resp_data,           m_rd);
            chk_val("resp_taint",     resp_taint,          m_rt);
            chk_val("resp_secret",    64'(resp_secret),    64'(m_rs));
            chk_val("issue_count",    64'(issue_count),    64'(m_ic));
            chk_val("secret_count",   64'(secret_count),   64'(m_sc));
        end
        // Predict the state after the coming posedge from the inputs it will sample.
        if (reset) begin
            m_qd.delete(); m_qt.delete();
            m_issuing = 1'b0; m_holding = 1'b0;
            m_pbw = 64'd0; m_pbwt = 64'd0;
            m_rd = 64'd0; m_rt = 64'd0; m_rs = 1'b0;
            m_ic = 32'd0; m_sc = 16'd0;
        end else begin
            acc = req_valid && (m_qd.size() < DEPTH);
            if (m_issuing) begin
                m_rd = pb_fn(m_cmd);
                m_rt = pbt_fn(m_cmd, m_cmd_t);
                m_rs = (m_cmd == SECRET);
                m_ic = m_ic + 32'd1;
                if (m_rs && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
                m_issuing = 1'b0;
                m_holding = 1'b1;
            end else if (m_holding) begin
                if (resp_ready) m_holding = 1'b0;
            end else if (m_qd.size() > 0) begin
                m_cmd   = m_qd.pop_front();
                m_cmd_t = m_qt.pop_front();
                m_pbw   = m_cmd;
                m_pbwt  = m_cmd_t;
                m_issuing = 1'b1;
            end
            if (acc) begin
                m_qd.push_back(req_data);
                m_qt.push_back(req_data_taint);
            end
        end
    end

    task automatic offer(input logic [63:0] d, input logic [63:0] t);
        req_valid      = 1'b1;
        req_data       = d;
        req_data_taint = t;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_data = 64'd0; req_data_taint = 64'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1; reset = 1'b0; mon_en = 1'b1;

        resp_ready = 1'b1;
        offer(64'h1234, 64'd0);
        idle(6);
        offer(SECRET, 64'd0);
        idle(6);

        // Backpressure: five offers against a stalled response fill the queue.
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) offer(64'h1000 + 64'(i), 64'(i) << 8);
        idle(4);
        resp_ready = 1'b1;
        idle(25);

        offer(64'h0, 64'h00FF);
        idle(6);

        // Reset landing in the cycle the command is on the bus.
        offer(64'h55, 64'h3);
        for (int i = 0; i < 10 && pb_wen !== 1'b1; i++) idle(1);
        chk_val("issue_wait", 64'(pb_wen), 64'd1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        offer(64'h77, 64'd0);
        idle(6);

        for (int c = 0; c < 3000; c++) begin
            req_valid      = ($urandom_range(0, 1) == 1);
            req_data       = ($urandom_range(0, 7) == 0) ? SECRET : {$urandom, $urandom};
            req_data_taint = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, $urandom};
            resp_ready     = ($urandom_range(0, 3) != 0);
            reset          = (c >= 1500 && c < 1503) || ($urandom_range(0, 399) == 0);
            idle(1);
        end
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        idle(10);
        @(negedge clock); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
